json_key_stats: RTL and testbench

- Streaming JSON object analyser. Consumes one ASCII character per accepted cycle.
- Validates each top-level object against a restricted JSON grammar:
  - nested objects up to MAX_DEPTH;
  - string values with backslash escapes;
  - unsigned integer values.
- Reports key counts and object statistics.
- Sits behind the character-stream front end; generalised, nesting-aware successor of the flat key counter.

---
 rtl/json_key_stats_pkg.sv | 37 +++
 rtl/json_key_stats_if.sv | 24 ++
 rtl/json_key_stats_sat_counter.sv | 29 ++
 rtl/json_key_stats.sv | 237 +++++++++++++++++++++++
 tb/tb_json_key_stats.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/json_key_stats_pkg.sv
// Shared types and character helpers for the streaming JSON key analyser.
package json_pkg;

    // Parser states; CLOSE is an action on the '}' edge, not a state.
    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_OBJ_OPEN   = 4'd1,
        ST_KEY_FIRST  = 4'd2,
        ST_KEY        = 4'd3,
        ST_KEY_ESC    = 4'd4,
        ST_COLON_WAIT = 4'd5,
        ST_VAL_WAIT   = 4'd6,
        ST_VAL_STR    = 4'd7,
        ST_VAL_ESC    = 4'd8,
        ST_VAL_NUM    = 4'd9,
        ST_AFTER_VAL  = 4'd10,
        ST_KEY_WAIT   = 4'd11,
        ST_ERROR      = 4'd12
    } state_e;

    localparam logic [7:0] CH_LBRACE = 8'h7B;
    localparam logic [7:0] CH_RBRACE = 8'h7D;
    localparam logic [7:0] CH_QUOTE  = 8'h22;
    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_BSLASH = 8'h5C;

    // Space, tab, line feed and carriage return are insignificant between tokens.
    function automatic logic is_ws(input logic [7:0] c);
        return (c == 8'h20) || (c == 8'h09) || (c == 8'h0A) || (c == 8'h0D);
    endfunction

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

endpackage

// File: rtl/json_key_stats_if.sv
// Character stream in, object statistics out.
interface json_key_stats_if #(
    parameter int CNT_W = 8,
    parameter int OBJ_W = 16
);
    logic [7:0]       i_char;
    logic             i_char_valid;
    logic [CNT_W-1:0] o_cur_num;
    logic [CNT_W-1:0] o_max_num;
    logic [OBJ_W-1:0] o_obj_count;
    logic             o_done;
    logic             o_err;
    logic [3:0]       o_depth;

    modport master (
        output i_char, i_char_valid,
        input  o_cur_num, o_max_num, o_obj_count, o_done, o_err, o_depth
    );

    modport slave (
        input  i_char, i_char_valid,
        output o_cur_num, o_max_num, o_obj_count, o_done, o_err, o_depth
    );
endinterface

// File: rtl/json_key_stats_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);
    localparam logic [W-1:0] Q_MAX = {W{1'b1}};

    logic [W-1:0] r_q;

    // Count register: holds at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != Q_MAX)) begin
            r_q <= r_q + W'(1);
        end else begin
            r_q <= r_q;
        end
    end

    assign q = r_q;
endmodule

// File: rtl/json_key_stats.sv
// Streaming JSON object validator: counts keys at every nesting level of each
// top-level object and keeps running statistics over the valid ones.
module json_key_stats
    import json_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int OBJ_W     = 16,
    parameter int MAX_DEPTH = 4
) (
    input logic             clk,
    input logic             reset,
    json_key_stats_if.slave bus
);
    localparam logic [3:0] MAX_D = 4'(MAX_DEPTH);

    state_e           r_state;
    state_e           w_next_state;
    logic [3:0]       r_depth;
    logic [3:0]       w_depth_next;
    logic [CNT_W-1:0] r_cur_num;
    logic [CNT_W-1:0] r_max_num;
    logic             r_done;
    logic             r_err;

    logic [7:0]       w_c;
    logic             w_key_inc;
    logic             w_key_clr;
    logic             w_bad;
    logic             w_close;
    logic             w_close_top;
    logic             w_resync;
    logic [CNT_W-1:0] w_key_count;
    logic [OBJ_W-1:0] w_obj_count;

    assign w_c = bus.i_char;

    // Per-object key total across all nesting levels.
    sat_counter #(.W(CNT_W)) u_key_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_key_inc),
        .clr   (w_key_clr),
        .q     (w_key_count)
    );

    // Number of valid top-level objects seen.
    sat_counter #(.W(OBJ_W)) u_obj_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_close_top),
        .clr   (1'b0),
        .q     (w_obj_count)
    );

    // Next-state, depth and event decode for the consumed character.
    always_comb begin
        w_next_state = r_state;
        w_depth_next = r_depth;
        w_key_inc    = 1'b0;
        w_key_clr    = 1'b0;
        w_bad        = 1'b0;
        w_close      = 1'b0;
        w_close_top  = 1'b0;
        w_resync     = 1'b0;
        if (bus.i_char_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_c == CH_LBRACE) begin
                        w_next_state = ST_OBJ_OPEN;
                        w_depth_next = 4'd1;
                        w_key_clr    = 1'b1;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
                ST_ERROR: begin
                    // The first '}' resyncs regardless of where the error happened.
                    if (w_c == CH_RBRACE) begin
                        w_next_state = ST_IDLE;
                        w_depth_next = 4'd0;
                        w_resync     = 1'b1;
                    end else begin
                        w_next_state = ST_ERROR;
                    end
                end
                default: begin
                    // A brace may only open an object where a value is expected.
                    if ((w_c == CH_LBRACE) && (r_state != ST_VAL_WAIT)) begin
                        w_bad = 1'b1;
                    end else begin
                        case (r_state)
                            ST_OBJ_OPEN: begin
                                if (is_ws(w_c))               w_next_state = ST_OBJ_OPEN;
                                else if (w_c == CH_QUOTE)     w_next_state = ST_KEY_FIRST;
                                else if (w_c == CH_RBRACE)    w_close      = 1'b1;
                                else                          w_bad        = 1'b1;
                            end
                            ST_KEY_FIRST: begin
                                if (w_c == CH_QUOTE)          w_bad        = 1'b1;
                                else if (w_c == CH_BSLASH)    w_next_state = ST_KEY_ESC;
                                else                          w_next_state = ST_KEY;
                            end
                            ST_KEY: begin
                                if (w_c == CH_QUOTE) begin
                                    w_next_state = ST_COLON_WAIT;
                                    w_key_inc    = 1'b1;
                                end else if (w_c == CH_BSLASH) begin
                                    w_next_state = ST_KEY_ESC;
                                end else begin
                                    w_next_state = ST_KEY;
                                end
                            end
                            ST_KEY_ESC: begin
                                w_next_state = ST_KEY;
                            end
                            ST_COLON_WAIT: begin
                                if (is_ws(w_c))               w_next_state = ST_COLON_WAIT;
                                else if (w_c == CH_COLON)     w_next_state = ST_VAL_WAIT;
                                else                          w_bad        = 1'b1;
                            end
                            ST_VAL_WAIT: begin
                                if (is_ws(w_c)) begin
                                    w_next_state = ST_VAL_WAIT;
                                end else if (w_c == CH_QUOTE) begin
                                    w_next_state = ST_VAL_STR;
                                end else if (is_digit(w_c)) begin
                                    w_next_state = ST_VAL_NUM;
                                end else if ((w_c == CH_LBRACE) && (r_depth < MAX_D)) begin
                                    w_next_state = ST_OBJ_OPEN;
                                    w_depth_next = r_depth + 4'd1;
                                end else begin
                                    w_bad = 1'b1;
                                end
                            end
                            ST_VAL_STR: begin
                                if (w_c == CH_QUOTE)          w_next_state = ST_AFTER_VAL;
                                else if (w_c == CH_BSLASH)    w_next_state = ST_VAL_ESC;
                                else                          w_next_state = ST_VAL_STR;
                            end
                            ST_VAL_ESC: begin
                                w_next_state = ST_VAL_STR;
                            end
                            ST_VAL_NUM: begin
                                if (is_digit(w_c))            w_next_state = ST_VAL_NUM;
                                else if (is_ws(w_c))          w_next_state = ST_AFTER_VAL;
                                else if (w_c == CH_COMMA)     w_next_state = ST_KEY_WAIT;
                                else if (w_c == CH_RBRACE)    w_close      = 1'b1;
                                else                          w_bad        = 1'b1;
                            end
                            ST_AFTER_VAL: begin
                                if (is_ws(w_c))               w_next_state = ST_AFTER_VAL;
                                else if (w_c == CH_COMMA)     w_next_state = ST_KEY_WAIT;
                                else if (w_c == CH_RBRACE)    w_close      = 1'b1;
                                else                          w_bad        = 1'b1;
                            end
                            ST_KEY_WAIT: begin
                                if (is_ws(w_c))               w_next_state = ST_KEY_WAIT;
                                else if (w_c == CH_QUOTE)     w_next_state = ST_KEY_FIRST;
                                else                          w_bad        = 1'b1;
                            end
                            default: begin
                                w_bad = 1'b1;
                            end
                        endcase
                    end
                end
            endcase

            // Closing brace: pop one level; leaving level 1 finishes the object.
            if (w_close) begin
                w_depth_next = r_depth - 4'd1;
                if (r_depth == 4'd1) begin
                    w_close_top  = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_AFTER_VAL;
                end
            end else begin
                w_close_top = 1'b0;
            end

            if (w_bad) begin
                w_next_state = ST_ERROR;
            end else begin
                w_resync = w_resync;
            end
        end else begin
            w_next_state = r_state;
            w_depth_next = r_depth;
        end
    end

    // Parser state and nesting depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_depth <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_depth <= w_depth_next;
        end
    end

    // Registered statistics and single-cycle event pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cur_num <= '0;
            r_max_num <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= w_close_top | w_resync;
            r_err  <= w_bad;
            if (w_close_top) begin
                r_cur_num <= w_key_count;
                if (w_key_count > r_max_num) begin
                    r_max_num <= w_key_count;
                end else begin
                    r_max_num <= r_max_num;
                end
            end else if (w_resync) begin
                r_cur_num <= '0;
                r_max_num <= r_max_num;
            end else begin
                r_cur_num <= r_cur_num;
                r_max_num <= r_max_num;
            end
        end
    end

    assign bus.o_cur_num   = r_cur_num;
    assign bus.o_max_num   = r_max_num;
    assign bus.o_obj_count = w_obj_count;
    assign bus.o_done      = r_done;
    assign bus.o_err       = r_err;
    assign bus.o_depth     = r_depth;
endmodule

// File: tb/tb_json_key_stats.sv
// Directed bench for json_key_stats with a grammar-level reference model.
module tb_json_key_stats;
    localparam int CNT_W   = 2;
    localparam int OBJ_W   = 4;
    localparam int MAX_D   = 2;
    localparam int KEY_MAX = 3;
    localparam int OBJ_MAX = 15;

    // Model modes (what the parser is waiting for next).
    localparam int M_IDLE = 0, M_OPEN = 1, M_KF = 2, M_KEY = 3, M_KESC = 4, M_COLON = 5,
                   M_VAL = 6, M_VSTR = 7, M_VESC = 8, M_VNUM = 9, M_AFTER = 10,
                   M_KWAIT = 11, M_ERR = 12;

    logic clk = 1'b0;
    logic reset = 1'b1;

    json_key_stats_if #(.CNT_W(CNT_W), .OBJ_W(OBJ_W)) bus ();

    json_key_stats #(.CNT_W(CNT_W), .OBJ_W(OBJ_W), .MAX_DEPTH(MAX_D)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int m_mode = M_IDLE;
    int m_depth = 0;
    int m_keys = 0;
    int e_cur = 0, e_max = 0, e_obj = 0, e_depth = 0;
    int e_done = 0, e_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode = M_IDLE; m_depth = 0; m_keys = 0;
        e_cur = 0; e_max = 0; e_obj = 0; e_depth = 0; e_done = 0; e_err = 0;
    endfunction

    function automatic void model_close();
        m_depth--;
        if (m_depth == 0) begin
            e_cur = m_keys;
            if (e_cur > e_max) e_max = e_cur;
            if (e_obj < OBJ_MAX) e_obj++;
            e_done = 1;
            m_mode = M_IDLE;
        end else begin
            m_mode = M_AFTER;
        end
    endfunction

    // Apply the grammar rules for one consumed character.
    function automatic void model_step(input byte c);
        bit ws, dig, q, bs, bad;
        ws  = (c == 8'h20) || (c == 8'h09) || (c == 8'h0A) || (c == 8'h0D);
        dig = (c >= 8'h30) && (c <= 8'h39);
        q   = (c == 8'h22);
        bs  = (c == 8'h5C);
        bad = 0;
        e_done = 0;
        e_err  = 0;
        if (m_mode == M_IDLE) begin
            if (c == 8'h7B) begin m_mode = M_OPEN; m_depth = 1; m_keys = 0; end
        end else if (m_mode == M_ERR) begin
            if (c == 8'h7D) begin e_cur = 0; e_done = 1; m_depth = 0; m_mode = M_IDLE; end
        end else if (c == 8'h7B && m_mode != M_VAL) begin
            bad = 1;
        end else begin
            case (m_mode)
                M_OPEN:  if (q) m_mode = M_KF; else if (c == 8'h7D) model_close(); else if (!ws) bad = 1;
                M_KF:    if (q) bad = 1; else if (bs) m_mode = M_KESC; else m_mode = M_KEY;
                M_KEY:   if (q) begin m_mode = M_COLON; if (m_keys < KEY_MAX) m_keys++; end
                         else if (bs) m_mode = M_KESC;
                M_KESC:  m_mode = M_KEY;
                M_COLON: if (c == 8'h3A) m_mode = M_VAL; else if (!ws) bad = 1;
                M_VAL:   if (q) m_mode = M_VSTR; else if (dig) m_mode = M_VNUM;
                         else if (c == 8'h7B) begin
                             if (m_depth < MAX_D) begin m_depth++; m_mode = M_OPEN; end else bad = 1;
                         end else if (!ws) bad = 1;
                M_VSTR:  if (q) m_mode = M_AFTER; else if (bs) m_mode = M_VESC;
                M_VESC:  m_mode = M_VSTR;
                M_VNUM:  if (ws) m_mode = M_AFTER; else if (c == 8'h2C) m_mode = M_KWAIT;
                         else if (c == 8'h7D) model_close(); else if (!dig) bad = 1;
                M_AFTER: if (c == 8'h2C) m_mode = M_KWAIT; else if (c == 8'h7D) model_close();
                         else if (!ws) bad = 1;
                M_KWAIT: if (q) m_mode = M_KF; else if (!ws) bad = 1;
                default: bad = 1;
            endcase
        end
        if (bad) begin m_mode = M_ERR; e_err = 1; end
        e_depth = m_depth;
    endfunction

    // One clock of stimulus, driven on the falling edge.
    task automatic cyc(input bit v, input byte c);
        @(negedge clk);
        bus.i_char       = c;
        bus.i_char_valid = v;
        if (v) model_step(c);
        else begin e_done = 0; e_err = 0; end
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) cyc(1'b1, s[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.i_char_valid = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Move to just after the edge that consumed the last driven character.
    task automatic sample();
        @(posedge clk);
        #2;
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(posedge clk) begin
        #1;
        chk("cur_num",   int'(bus.o_cur_num),   e_cur);
        chk("max_num",   int'(bus.o_max_num),   e_max);
        chk("obj_count", int'(bus.o_obj_count), e_obj);
        chk("done",      int'(bus.o_done),      e_done);
        chk("err",       int'(bus.o_err),       e_err);
        chk("depth",     int'(bus.o_depth),     e_depth);
    end

    initial begin
        bus.i_char = 8'h00;
        bus.i_char_valid = 1'b0;
        model_reset();
        do_reset();
        chk("reset_cur", int'(bus.o_cur_num), 0);
        chk("reset_obj", int'(bus.o_obj_count), 0);

        // Nested object, three keys in total.
        send("{\"a\":\"x\",\"b\":{\"c\":\"y\"}}");
        sample();
        chk("t1_done", int'(bus.o_done), 1);
        chk("t1_cur", int'(bus.o_cur_num), 3);
        chk("t1_max", int'(bus.o_max_num), 3);
        chk("t1_obj", int'(bus.o_obj_count), 1);
        chk("t1_depth", int'(bus.o_depth), 0);

        // Escapes in key and value, number value, then an empty object.
        do_reset();
        send("{\"k\\\"q\":\"v\\\\\",\"n\":123}");
        sample();
        chk("t2_cur_a", int'(bus.o_cur_num), 2);
        send("  {}");
        sample();
        chk("t2_cur_b", int'(bus.o_cur_num), 0);
        chk("t2_max", int'(bus.o_max_num), 2);
        chk("t2_obj", int'(bus.o_obj_count), 2);

        // Empty key is an error; resync on '}', then a good object.
        send("{\"\"");
        sample();
        chk("t3_err", int'(bus.o_err), 1);
        send(":\"x\"}");
        sample();
        chk("t3_done", int'(bus.o_done), 1);
        chk("t3_cur", int'(bus.o_cur_num), 0);
        chk("t3_obj", int'(bus.o_obj_count), 2);
        send("{\"a\":1}");
        sample();
        chk("t3_cur2", int'(bus.o_cur_num), 1);
        chk("t3_obj2", int'(bus.o_obj_count), 3);

        // Third level exceeds the depth limit of two.
        send("{\"a\":{\"b\":{");
        sample();
        chk("t4_err", int'(bus.o_err), 1);
        chk("t4_depth_err", int'(bus.o_depth), 2);
        send("\"c\":1}");
        sample();
        chk("t4_done", int'(bus.o_done), 1);
        chk("t4_cur", int'(bus.o_cur_num), 0);
        chk("t4_depth", int'(bus.o_depth), 0);
        send("}}");

        // Five keys saturate a two-bit key counter.
        do_reset();
        send("{\"a\":1,\"b\":2,\"c\":3,\"d\":4,\"e\":5}");
        sample();
        chk("t5_cur", int'(bus.o_cur_num), 3);
        chk("t5_max", int'(bus.o_max_num), 3);

        // Reset in the middle of a string value, idle gap, fresh object.
        send("{\"q\":\"ab");
        sample();
        chk("t6_depth_mid", int'(bus.o_depth), 1);
        do_reset();
        chk("t6_rst_max", int'(bus.o_max_num), 0);
        chk("t6_rst_obj", int'(bus.o_obj_count), 0);
        chk("t6_rst_done", int'(bus.o_done), 0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h7B);
        send("{\"z\":0}");
        sample();
        chk("t6_cur", int'(bus.o_cur_num), 1);
        chk("t6_obj", int'(bus.o_obj_count), 1);

        // Empty nested object, then back-to-back objects saturating obj_count.
        send("{\"a\":{}}");
        sample();
        chk("t7_cur", int'(bus.o_cur_num), 1);
        for (int i = 0; i < 16; i++) send("{}");
        sample();
        chk("t7_obj_sat", int'(bus.o_obj_count), 15);
        chk("t7_cur0", int'(bus.o_cur_num), 0);
        chk("t7_max", int'(bus.o_max_num), 1);

        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
